// File: rtl/time_counter.sv
// BCD hh:mm:ss time-of-day counter with 24h or 12h+pm mode, validated
// edge-triggered loads, and registered minute/hour/day rollover pulses.
module time_counter #(
    parameter bit MODE_24H = 1'b1
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       sec_en,
    input  logic       set_req,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       set_pm,
    output logic       set_ack,
    output logic       set_err,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       min_tick,
    output logic       hour_tick,
    output logic       day_tick
);

    localparam logic [7:0] HH_RESET = MODE_24H ? 8'h00 : 8'h12;

    logic [7:0] hh_q, hh_d;
    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;
    logic       pm_q, pm_d;
    logic       set_ack_q, set_ack_d;
    logic       set_err_q, set_err_d;
    logic       min_tick_q, min_tick_d;
    logic       hour_tick_q, hour_tick_d;
    logic       day_tick_q, day_tick_d;
    logic       req_prev_q, req_prev_d;

    logic req_edge;
    logic hours_ok;
    logic set_valid;

    function automatic logic digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Increment a two-digit BCD value; callers handle the upper wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'h0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign req_edge = set_req && !req_prev_q;

    always_comb begin
        if (MODE_24H) begin
            hours_ok = (set_hh <= 8'h23);
        end else begin
            hours_ok = (set_hh >= 8'h01) && (set_hh <= 8'h12);
        end
    end

    assign set_valid = digits_ok(set_hh) && digits_ok(set_mm) && digits_ok(set_ss)
                     && (set_ss <= 8'h59) && (set_mm <= 8'h59) && hours_ok;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        pm_d        = pm_q;
        set_ack_d   = 1'b0;
        set_err_d   = 1'b0;
        min_tick_d  = 1'b0;
        hour_tick_d = 1'b0;
        day_tick_d  = 1'b0;
        req_prev_d  = set_req;

        if (req_edge && set_valid) begin
            // An accepted load takes priority and swallows any coincident tick.
            hh_d      = set_hh;
            mm_d      = set_mm;
            ss_d      = set_ss;
            pm_d      = MODE_24H ? 1'b0 : set_pm;
            set_ack_d = 1'b1;
        end else begin
            set_err_d = req_edge;
            if (sec_en) begin
                if (ss_q == 8'h59) begin
                    ss_d       = 8'h00;
                    min_tick_d = 1'b1;
                    if (mm_q == 8'h59) begin
                        mm_d        = 8'h00;
                        hour_tick_d = 1'b1;
                        if (MODE_24H) begin
                            if (hh_q == 8'h23) begin
                                hh_d       = 8'h00;
                                day_tick_d = 1'b1;
                            end else begin
                                hh_d = bcd_inc(hh_q);
                            end
                        end else if (hh_q == 8'h12) begin
                            hh_d = 8'h01;
                        end else if (hh_q == 8'h11) begin
                            // 11:59:59 pm -> 12:00:00 am is the day boundary.
                            hh_d       = 8'h12;
                            pm_d       = !pm_q;
                            day_tick_d = pm_q;
                        end else begin
                            hh_d = bcd_inc(hh_q);
                        end
                    end else begin
                        mm_d = bcd_inc(mm_q);
                    end
                end else begin
                    ss_d = bcd_inc(ss_q);
                end
            end
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            hh_q        <= HH_RESET;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            pm_q        <= 1'b0;
            set_ack_q   <= 1'b0;
            set_err_q   <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
            // NOTE: reset to 1 so a set_req already high at release is not seen as a new edge.
            req_prev_q  <= 1'b1;
        end else begin
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            pm_q        <= pm_d;
            set_ack_q   <= set_ack_d;
            set_err_q   <= set_err_d;
            min_tick_q  <= min_tick_d;
            hour_tick_q <= hour_tick_d;
            day_tick_q  <= day_tick_d;
            req_prev_q  <= req_prev_d;
        end
    end

    assign hh        = hh_q;
    assign mm        = mm_q;
    assign ss        = ss_q;
    assign pm        = pm_q;
    assign set_ack   = set_ack_q;
    assign set_err   = set_err_q;
    assign min_tick  = min_tick_q;
    assign hour_tick = hour_tick_q;
    assign day_tick  = day_tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: a 24h instance and a 12h instance side by side.
// Observation word per instance = {hh, mm, ss, pm, ack, err, min, hour, day}.
module tb_time_counter;

    logic ck = 1'b0;
    logic reset;

    logic       a_sec_en, a_set_req, a_set_pm;
    logic [7:0] a_set_hh, a_set_mm, a_set_ss;
    logic       a_ack, a_err, a_pm, a_min, a_hour, a_day;
    logic [7:0] a_hh, a_mm, a_ss;

    logic       b_sec_en, b_set_req, b_set_pm;
    logic [7:0] b_set_hh, b_set_mm, b_set_ss;
    logic       b_ack, b_err, b_pm, b_min, b_hour, b_day;
    logic [7:0] b_hh, b_mm, b_ss;

    int vectors     = 0;
    int miscompares = 0;

    logic [29:0] obs_a, obs_b;
    assign obs_a = {a_hh, a_mm, a_ss, a_pm, a_ack, a_err, a_min, a_hour, a_day};
    assign obs_b = {b_hh, b_mm, b_ss, b_pm, b_ack, b_err, b_min, b_hour, b_day};

    always #5 ck = ~ck;

    time_counter #(.MODE_24H(1'b1)) dut_24 (
        .ck(ck), .reset(reset), .sec_en(a_sec_en), .set_req(a_set_req),
        .set_hh(a_set_hh), .set_mm(a_set_mm), .set_ss(a_set_ss), .set_pm(a_set_pm),
        .set_ack(a_ack), .set_err(a_err), .hh(a_hh), .mm(a_mm), .ss(a_ss), .pm(a_pm),
        .min_tick(a_min), .hour_tick(a_hour), .day_tick(a_day)
    );

    time_counter #(.MODE_24H(1'b0)) dut_12 (
        .ck(ck), .reset(reset), .sec_en(b_sec_en), .set_req(b_set_req),
        .set_hh(b_set_hh), .set_mm(b_set_mm), .set_ss(b_set_ss), .set_pm(b_set_pm),
        .set_ack(b_ack), .set_err(b_err), .hh(b_hh), .mm(b_mm), .ss(b_ss), .pm(b_pm),
        .min_tick(b_min), .hour_tick(b_hour), .day_tick(b_day)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic load_a(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic en);
        a_set_req = 1'b0; a_sec_en = 1'b0;
        step();
        a_set_hh = h; a_set_mm = m; a_set_ss = s; a_set_req = 1'b1; a_sec_en = en;
        step();
        a_set_req = 1'b0; a_sec_en = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic p, input logic en);
        b_set_req = 1'b0; b_sec_en = 1'b0;
        step();
        b_set_hh = h; b_set_mm = m; b_set_ss = s; b_set_pm = p; b_set_req = 1'b1; b_sec_en = en;
        step();
        b_set_req = 1'b0; b_sec_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_sec_en = 1'b0; a_set_req = 1'b0; a_set_pm = 1'b0;
        a_set_hh = 8'h00; a_set_mm = 8'h00; a_set_ss = 8'h00;
        b_sec_en = 1'b0; b_set_req = 1'b0; b_set_pm = 1'b0;
        b_set_hh = 8'h00; b_set_mm = 8'h00; b_set_ss = 8'h00;
        #1;
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL reset_24h: got %h want %h", obs_a, {24'h000000, 6'b0});
        end
        vectors++;
        if (obs_b !== {8'h12, 8'h00, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL reset_12h: got %h want %h", obs_b, {24'h120000, 6'b0});
        end
        step(); step();
        reset = 1'b0;
        step();
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL reset_release_24h: got %h", obs_a);
        end
    endtask

    task automatic test_min_roll();
        load_a(8'h00, 8'h00, 8'h58, 1'b0);
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h58, 6'b010000}) begin
            miscompares++; $display("FAIL min_roll_load: got %h want %h", obs_a, {24'h000058, 6'b010000});
        end
        a_sec_en = 1'b1;
        step();
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h59, 6'b000000}) begin
            miscompares++; $display("FAIL min_roll_59: got %h want %h", obs_a, {24'h000059, 6'b0});
        end
        step();
        vectors++;
        if (obs_a !== {8'h00, 8'h01, 8'h00, 6'b000100}) begin
            miscompares++; $display("FAIL min_roll_wrap: got %h want %h", obs_a, {24'h000100, 6'b000100});
        end
        a_sec_en = 1'b0;
        step();
        vectors++;
        if (obs_a !== {8'h00, 8'h01, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL min_roll_hold: got %h want %h", obs_a, {24'h000100, 6'b0});
        end
    endtask

    task automatic test_day_roll_24h();
        load_a(8'h23, 8'h59, 8'h59, 1'b0);
        a_sec_en = 1'b1;
        step();
        a_sec_en = 1'b0;
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h00, 6'b000111}) begin
            miscompares++; $display("FAIL day_roll_24h: got %h want %h", obs_a, {24'h000000, 6'b000111});
        end
        step();
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL day_roll_24h_clear: got %h", obs_a);
        end
    endtask

    task automatic test_invalid();
        load_a(8'h00, 8'h00, 8'h5A, 1'b0);
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h00, 6'b001000}) begin
            miscompares++; $display("FAIL invalid_ss5A: got %h want %h", obs_a, {24'h000000, 6'b001000});
        end
        step();
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL invalid_err_one_cycle: got %h", obs_a);
        end
        // Rejected hour 24 with a coincident tick: the tick still applies.
        load_a(8'h24, 8'h00, 8'h00, 1'b1);
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h01, 6'b001000}) begin
            miscompares++; $display("FAIL invalid_hh24_tick: got %h want %h", obs_a, {24'h000001, 6'b001000});
        end
        load_a(8'h00, 8'h60, 8'h00, 1'b0);
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h01, 6'b001000}) begin
            miscompares++; $display("FAIL invalid_mm60: got %h", obs_a);
        end
        load_a(8'h0A, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h01, 6'b001000}) begin
            miscompares++; $display("FAIL invalid_hh0A: got %h", obs_a);
        end
    endtask

    task automatic test_held_req();
        int errs = 0;
        int acks = 0;
        a_set_req = 1'b0;
        step();
        a_set_hh = 8'h00; a_set_mm = 8'h00; a_set_ss = 8'h5A; a_set_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            errs += int'(a_err);
        end
        vectors++;
        if (errs != 1) begin
            miscompares++; $display("FAIL held_req_err_count: got %0d want 1", errs);
        end
        a_set_req = 1'b0;
        step();
        a_set_hh = 8'h01; a_set_mm = 8'h02; a_set_ss = 8'h03; a_set_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            acks += int'(a_ack);
        end
        a_set_req = 1'b0;
        vectors++;
        if (acks != 1) begin
            miscompares++; $display("FAIL held_req_ack_count: got %0d want 1", acks);
        end
        vectors++;
        if (obs_a !== {8'h01, 8'h02, 8'h03, 6'b000000}) begin
            miscompares++; $display("FAIL held_req_time: got %h want %h", obs_a, {24'h010203, 6'b0});
        end
    endtask

    task automatic test_load_vs_tick();
        load_a(8'h00, 8'h59, 8'h59, 1'b0);
        load_a(8'h10, 8'h20, 8'h30, 1'b1);
        vectors++;
        if (obs_a !== {8'h10, 8'h20, 8'h30, 6'b010000}) begin
            miscompares++; $display("FAIL load_vs_tick: got %h want %h", obs_a, {24'h102030, 6'b010000});
        end
    endtask

    task automatic test_back_to_back();
        a_sec_en = 1'b1;
        step(); step(); step();
        a_sec_en = 1'b0;
        vectors++;
        if (obs_a !== {8'h10, 8'h20, 8'h33, 6'b000000}) begin
            miscompares++; $display("FAIL back_to_back: got %h want %h", obs_a, {24'h102033, 6'b0});
        end
    endtask

    task automatic test_12h();
        load_b(8'h11, 8'h59, 8'h59, 1'b1, 1'b0);
        vectors++;
        if (obs_b !== {8'h11, 8'h59, 8'h59, 6'b110000}) begin
            miscompares++; $display("FAIL 12h_load_pm: got %h", obs_b);
        end
        b_sec_en = 1'b1;
        step();
        b_sec_en = 1'b0;
        vectors++;
        if (obs_b !== {8'h12, 8'h00, 8'h00, 6'b000111}) begin
            miscompares++; $display("FAIL 12h_pm_to_am_day: got %h want %h", obs_b, {24'h120000, 6'b000111});
        end
        load_b(8'h11, 8'h59, 8'h59, 1'b0, 1'b1);
        b_sec_en = 1'b1;
        step();
        b_sec_en = 1'b0;
        vectors++;
        if (obs_b !== {8'h12, 8'h00, 8'h00, 6'b100110}) begin
            miscompares++; $display("FAIL 12h_am_to_pm: got %h want %h", obs_b, {24'h120000, 6'b100110});
        end
        load_b(8'h12, 8'h59, 8'h59, 1'b1, 1'b0);
        b_sec_en = 1'b1;
        step();
        b_sec_en = 1'b0;
        vectors++;
        if (obs_b !== {8'h01, 8'h00, 8'h00, 6'b100110}) begin
            miscompares++; $display("FAIL 12h_12_to_01: got %h want %h", obs_b, {24'h010000, 6'b100110});
        end
        load_b(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (obs_b !== {8'h01, 8'h00, 8'h00, 6'b101000}) begin
            miscompares++; $display("FAIL 12h_invalid_hh00: got %h", obs_b);
        end
        load_b(8'h13, 8'h00, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (obs_b !== {8'h01, 8'h00, 8'h00, 6'b101000}) begin
            miscompares++; $display("FAIL 12h_invalid_hh13: got %h", obs_b);
        end
    endtask

    task automatic test_async_reset();
        load_a(8'h05, 8'h06, 8'h07, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL async_reset_24h: got %h want %h", obs_a, {24'h000000, 6'b0});
        end
        vectors++;
        if (obs_b !== {8'h12, 8'h00, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL async_reset_12h: got %h", obs_b);
        end
        step();
        reset = 1'b0;
        step();
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL async_reset_release: got %h", obs_a);
        end
    endtask

    task automatic test_reset_req();
        a_set_hh = 8'h07; a_set_mm = 8'h08; a_set_ss = 8'h09;
        reset = 1'b1;
        a_set_req = 1'b1;
        step();
        reset = 1'b0;
        step(); step();
        vectors++;
        if (obs_a !== {8'h00, 8'h00, 8'h00, 6'b000000}) begin
            miscompares++; $display("FAIL reset_req_no_ack: got %h", obs_a);
        end
        a_set_req = 1'b0;
        step();
        a_set_req = 1'b1;
        step();
        a_set_req = 1'b0;
        vectors++;
        if (obs_a !== {8'h07, 8'h08, 8'h09, 6'b010000}) begin
            miscompares++; $display("FAIL reset_req_reraise: got %h want %h", obs_a, {24'h070809, 6'b010000});
        end
    endtask

    initial begin
        test_reset();
        test_min_roll();
        test_day_roll_24h();
        test_invalid();
        test_held_req();
        test_load_vs_tick();
        test_back_to_back();
        test_12h();
        test_async_reset();
        test_reset_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
